// File: rtl/sdc_byte_feeder_pkg.sv
// Shared definitions for the SD-card byte feeder: FSM state encoding and sector defaults.
package sdc_byte_feeder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain,
        StPad
    } feeder_state_e;

    localparam int unsigned SDC_FIFO_DEPTH   = 16;
    localparam int unsigned SDC_SECTOR_BYTES = 512;
    localparam logic [7:0]  SDC_PAD_BYTE     = 8'h00;

endpackage

// File: rtl/sdc_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
module sdc_byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Caller guarantees push only when not full and pop only when not empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/sdc_byte_feeder.sv
// Buffers source bytes and feeds the SD writer sector by sector, padding a flushed sector.
module sdc_byte_feeder
    import sdc_byte_feeder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = SDC_FIFO_DEPTH,
    parameter int unsigned SECTOR_BYTES = SDC_SECTOR_BYTES,
    parameter logic [7:0]  PAD_BYTE     = SDC_PAD_BYTE
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [7:0]                      wr_data,
    output logic                            wr_valid,
    input  logic                            wr_ready,
    output logic                            nextAddr,
    output logic                            sector_start,
    output logic                            sector_end,
    output logic [$clog2(SECTOR_BYTES)-1:0] byte_idx,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            busy
);
    localparam int unsigned IW = $clog2(SECTOR_BYTES);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    feeder_state_e state;
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic [IW-1:0] idx_next;
    logic [CW-1:0] count_next;

    sdc_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    always_comb begin
        in_ready     = !reset && (state == StIdle || state == StStream)
                       && (fifo_count < CW'(FIFO_DEPTH));
        wr_valid     = !reset && (state == StPad || fifo_count != '0);
        wr_data      = (state == StPad) ? PAD_BYTE : head;
        nextAddr     = wr_valid && wr_ready;
        sector_start = nextAddr && (byte_idx == '0);
        sector_end   = nextAddr && (byte_idx == IW'(SECTOR_BYTES - 1));
        busy         = !reset && (state != StIdle);
        push         = in_valid && in_ready;
        // Padding bytes are synthesised, so they never drain the FIFO.
        pop          = nextAddr && (state != StPad);
        idx_next     = nextAddr ? byte_idx + 1'b1 : byte_idx;
        count_next   = fifo_count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            byte_idx <= '0;
        end else begin
            byte_idx <= idx_next;
            unique case (state)
                StIdle: begin
                    if (flush && fifo_count != '0) begin
                        state <= StDrain;
                    end else if (nextAddr) begin
                        state <= StStream;
                    end
                end
                StStream: begin
                    // A flush looks at the sector position after this cycle's consume.
                    if (flush) begin
                        state <= (idx_next != '0 || count_next != '0) ? StDrain : StIdle;
                    end else if (sector_end) begin
                        state <= StIdle;
                    end
                end
                StDrain: begin
                    if (fifo_count == '0) begin
                        state <= (byte_idx != '0) ? StPad : StIdle;
                    end
                end
                StPad: begin
                    if (sector_end) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sdc_byte_feeder.sv
// Self-checking bench for sdc_byte_feeder: queue-based reference model plus directed scenarios.
module tb_sdc_byte_feeder;
    localparam int DEPTH = 16;
    localparam int SB    = 512;
    localparam int M_IDLE = 0, M_STREAM = 1, M_DRAIN = 2, M_PAD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       flush = 1'b0;
    logic       wr_ready = 1'b0;
    logic       in_ready;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       nextAddr;
    logic       sector_start;
    logic       sector_end;
    logic [8:0] byte_idx;
    logic [4:0] fifo_count;
    logic       busy;

    sdc_byte_feeder #(
        .FIFO_DEPTH   (DEPTH),
        .SECTOR_BYTES (SB),
        .PAD_BYTE     (8'h00)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .nextAddr     (nextAddr),
        .sector_start (sector_start),
        .sector_end   (sector_end),
        .byte_idx     (byte_idx),
        .fifo_count   (fifo_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: buffered bytes, position in sector, operating mode.
    logic [7:0] q[$];
    int idx = 0;
    int mode = M_IDLE;

    // Observation counters over DUT pulses.
    int pulses = 0, start_at = 0, end_at = 0, pad_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_in_ready();
        return !reset && (mode == M_IDLE || mode == M_STREAM) && (q.size() < DEPTH);
    endfunction

    function automatic bit exp_wr_valid();
        return !reset && (mode == M_PAD || q.size() != 0);
    endfunction

    task automatic compare();
        bit v, n;
        v = exp_wr_valid();
        n = v && wr_ready;
        chk("in_ready", 32'(in_ready), 32'(exp_in_ready()));
        chk("wr_valid", 32'(wr_valid), 32'(v));
        chk("nextAddr", 32'(nextAddr), 32'(n));
        chk("sector_start", 32'(sector_start), 32'(n && idx == 0));
        chk("sector_end", 32'(sector_end), 32'(n && idx == SB - 1));
        chk("byte_idx", 32'(byte_idx), 32'(idx));
        chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        chk("busy", 32'(busy), 32'(!reset && mode != M_IDLE));
        if (v) chk("wr_data", 32'(wr_data), (mode == M_PAD) ? 32'h0 : 32'(q[0]));
        if (nextAddr === 1'b1) begin
            pulses++;
            if (sector_start === 1'b1) start_at = pulses;
            if (sector_end === 1'b1) end_at = pulses;
            if (wr_data === 8'h00) pad_seen++;
        end
    endtask

    task automatic model_step();
        bit push, cons, se;
        int old_size, idx_post;
        if (reset) begin
            q.delete();
            idx = 0;
            mode = M_IDLE;
            return;
        end
        push = in_valid && exp_in_ready();
        cons = exp_wr_valid() && wr_ready;
        se = cons && idx == SB - 1;
        old_size = q.size();
        if (cons && mode != M_PAD) void'(q.pop_front());
        if (push) q.push_back(in_data);
        idx_post = cons ? (idx + 1) % SB : idx;
        case (mode)
            M_IDLE:   if (flush && old_size != 0) mode = M_DRAIN;
                      else if (cons) mode = M_STREAM;
            M_STREAM: if (flush) mode = (idx_post != 0 || q.size() != 0) ? M_DRAIN : M_IDLE;
                      else if (se) mode = M_IDLE;
            M_DRAIN:  if (old_size == 0) mode = (idx != 0) ? M_PAD : M_IDLE;
            M_PAD:    if (se) mode = M_IDLE;
            default:  mode = M_IDLE;
        endcase
        idx = idx_post;
    endtask

    initial begin
        @(posedge clk);
        model_step();
        forever begin
            @(negedge clk);
            compare();
            @(posedge clk);
            model_step();
        end
    end

    task automatic clear_counts();
        pulses = 0; start_at = 0; end_at = 0; pad_seen = 0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        in_data = d;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL push_timeout actual=stalled required=accepted t=%0t", $time);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        @(posedge clk);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy && fifo_count == 0) begin
                @(posedge clk); #1;
                return;
            end
        end
        checks++; failures++;
        $display("FAIL idle_timeout actual=busy required=idle t=%0t", $time);
        @(posedge clk); #1;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    initial begin
        int accepted;
        bit got;
        // Reset state
        reset_dut();
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        @(posedge clk); #1;

        // Full sector streaming
        clear_counts();
        wr_ready = 1'b1;
        for (int i = 0; i < SB; i++) push_byte(8'(i));
        wait_idle(50);
        chk("stream_pulses", 32'(pulses), 32'd512);
        chk("stream_start_at", 32'(start_at), 32'd1);
        chk("stream_end_at", 32'(end_at), 32'd512);
        chk("stream_byte_idx", 32'(byte_idx), 32'd0);
        chk("stream_busy", 32'(busy), 32'd0);

        // Backpressure
        reset_dut();
        wr_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'hA0 + 8'(i);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) accepted++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_accepted", 32'(accepted), 32'd16);
        chk("bp_fifo_count", 32'(fifo_count), 32'd16);
        chk("bp_wr_data", 32'(wr_data), 32'hA0);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_model_size", 32'(q.size()), 32'd16);
        @(posedge clk); #1;
        wr_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_drain_idx", 32'(byte_idx), 32'd16);
        chk("bp_drain_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        pulse_flush();
        wait_idle(1000);
        chk("bp_flush_idx", 32'(byte_idx), 32'd0);

        // Flush after 10 bytes
        reset_dut();
        clear_counts();
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i));
        pulse_flush();
        wait_idle(1000);
        chk("flush_pulses", 32'(pulses), 32'd512);
        chk("flush_pads", 32'(pad_seen), 32'd502);
        chk("flush_end_at", 32'(end_at), 32'd512);
        chk("flush_byte_idx", 32'(byte_idx), 32'd0);

        // Flush coinciding with sector_end, FIFO empty afterwards
        reset_dut();
        clear_counts();
        wr_ready = 1'b1;
        for (int i = 0; i < SB - 1; i++) push_byte(8'(i) | 8'h01);
        @(posedge clk); #1;
        wr_ready = 1'b0;
        push_byte(8'h55);
        wr_ready = 1'b1;
        pulse_flush();
        @(negedge clk);
        chk("bnd_busy", 32'(busy), 32'd0);
        chk("bnd_byte_idx", 32'(byte_idx), 32'd0);
        chk("bnd_end_at", 32'(end_at), 32'd512);
        repeat (5) @(posedge clk);
        #1;
        chk("bnd_no_pad", 32'(pulses), 32'd512);

        // Reset in the middle of padding
        reset_dut();
        clear_counts();
        wr_ready = 1'b1;
        for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i));
        pulse_flush();
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (pad_seen >= 100) got = 1'b1;
        end
        chk("midpad_reached", 32'(got), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midpad_fifo_count", 32'(fifo_count), 32'd0);
        chk("midpad_byte_idx", 32'(byte_idx), 32'd0);
        chk("midpad_wr_valid", 32'(wr_valid), 32'd0);
        chk("midpad_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Flush while idle and empty
        reset_dut();
        clear_counts();
        wr_ready = 1'b1;
        pulse_flush();
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_flush_pulses", 32'(pulses), 32'd0);
        chk("idle_flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Randomised traffic against the model
        reset_dut();
        for (int c = 0; c < 6000; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data  = 8'($urandom);
            wr_ready = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 199) == 0);
            reset    = ($urandom_range(0, 2499) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
